counter_seq_monitor: RTL and testbench
======================================

// Module: counter_seq_monitor
// PURPOSE
//  Receive-side checker for the 4-bit counter output stream. Samples the count
//  bus on qualified cycles, predicts the next value (increment mod 2^WIDTH, or 0
//  after an observed clear) and flags every deviation.
//  Sits beside any counter instance, in RTL or in a bench, as a self-checking
//  sink. Reports lock, mismatches, error and wrap statistics.
// PARAMETERS
//  WIDTH     4  width of the observed count bus
//  ERR_CNT_W 8  width of the err_count and wrap_count statistics counters
// PORTS
//  clk         in   1          rising-edge clock; the only clock in the block
//  reset       in   1          asynchronous, active-low reset
//  cnt_in      in   WIDTH      observed counter value
//  cnt_valid   in   1          cnt_in is qualified this cycle
//  sync_clr    in   1          observed counter was cleared; next valid sample must be 0
//  clr_err     in   1          clears err_count and err_sticky
//  locked      out  1          monitor holds a valid prediction (state LOCK)
//  mismatch    out  1          one-cycle pulse: a checked sample differed from prediction
//  err_sticky  out  1          set on any mismatch; held until clr_err or reset
//  err_count   out  ERR_CNT_W  mismatches seen; saturates at all-ones
//  wrap_count  out  ERR_CNT_W  correct all-ones samples (wraps); saturates at all-ones
// BEHAVIOUR
//  - reset low: asynchronously forces state=HUNT, exp=0, and all outputs to 0.
//  - All outputs are registered. Each is updated on the edge that samples the input.
//  - cnt_valid=0 and sync_clr=0: no state change. A gap is not an error.
//  - sync_clr=1 has priority over comparison in every state:
//    - sets exp=0 and state=LOCK;
//    - the cnt_in of that cycle is not checked.
//  - HUNT, valid sample v: exp <= v+1 (mod 2^WIDTH), go LOCK. No check on v.
//  - LOCK, valid sample s:
//    - s==exp: exp <= s+1 (mod 2^WIDTH). If s is all-ones, wrap_count++ (saturating).
//    - s!=exp: mismatch=1 for exactly one cycle, err_count++ (saturating),
//      err_sticky=1, go FAULT, locked=0.
//  - FAULT: valid samples are not checked and mismatch is not re-raised.
//    Only sync_clr or reset leaves this state, unless the option below is enabled.
//  - clr_err and a new mismatch on the same edge: the mismatch wins.
//    err_count=1 and err_sticky=1 afterwards.
//  - locked = (state==LOCK), as registered.
//  - Saturated counters hold all-ones until clr_err (err_count only) or reset.
//    wrap_count is cleared only by reset.
// CONFIGURATION
//  COUNTER_MON_RESYNC_EN
//    defined: in FAULT, the next valid sample re-seeds exp <= v+1 and the state
//      returns to LOCK, the same as HUNT. err_sticky stays set.
//    undefined: FAULT is exited only by sync_clr or reset.
// STRUCTURE
//  - Shared package counter_mon_pkg:
//    - state typedef {HUNT=2'd0, LOCK=2'd1, FAULT=2'd2};
//    - default WIDTH and ERR_CNT_W constants.
//  - One sub-module, mon_sat_counter (parameterised width; inc and clr inputs),
//    instanced twice: once for err_count, once for wrap_count.
//  - The FSM and the prediction register live in the top level.
// TESTING
//  1. Reset, then valid samples 0..15,0..3 -> locked=1 from the 2nd cycle,
//     mismatch never 1, wrap_count=1, err_count=0.
//  2. Locked at 5, then sample 7 -> mismatch=1 for one cycle after the 7 edge,
//     err_count=1, err_sticky=1, locked=0.
//  3. Locked at 9, sync_clr with cnt_in=9 -> no mismatch, next sample 0 passes.
//     Repeat with next sample 10 -> mismatch.
//  4. clr_err on the same edge as a mismatch -> err_count=1, err_sticky=1.
//     clr_err alone on the next cycle -> both 0.
//  5. reset low mid-LOCK between edges -> outputs 0 immediately.
//     After release, first sample 12 re-seeds and 13 passes.
//  6. After a FAULT, samples 3,4,5 -> with COUNTER_MON_RESYNC_EN locked=1 again;
//     without it locked stays 0 and err_count stays 1.
//  7. Force 300 mismatches (toggle sync_clr/bad samples) -> err_count holds 255.

Source files
------------

// File: rtl/counter_mon_pkg.sv
// Shared types and default sizes for the counter sequence monitor.
package counter_mon_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LOCK  = 2'd1,
        FAULT = 2'd2
    } mon_state_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_ERR_CNT_W = 8;

endpackage

// File: rtl/mon_sat_counter.sv
// Saturating statistics counter. An increment on the same edge as a clear
// yields 1, so a fresh event is never lost to a simultaneous clear.
module mon_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        if (v != {W{1'b1}}) begin
            r = v + {{(W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    always_comb begin
        count_d = count_q;
        if (clr && inc) begin
            count_d = {{(W-1){1'b0}}, 1'b1};
        end else if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_seq_monitor.sv
// Receive-side checker for a free-running counter stream: predicts the next
// count and flags deviations. Optional macro COUNTER_MON_RESYNC_EN lets FAULT re-seed.
module counter_seq_monitor
    import counter_mon_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     cnt_in,
    input  logic                 cnt_valid,
    input  logic                 sync_clr,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 mismatch,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [ERR_CNT_W-1:0] wrap_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    mon_state_t       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             mismatch_q, mismatch_d;
    logic             err_sticky_q, err_sticky_d;
    logic             locked_q, locked_d;
    logic             err_inc, wrap_inc;

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        mismatch_d   = 1'b0;
        err_sticky_d = clr_err ? 1'b0 : err_sticky_q;
        err_inc      = 1'b0;
        wrap_inc     = 1'b0;
        // A clear overrides any comparison; that cycle's sample is ignored.
        if (sync_clr) begin
            exp_d   = '0;
            state_d = LOCK;
        end else if (cnt_valid) begin
            case (state_q)
                HUNT: begin
                    exp_d   = cnt_in + ONE;
                    state_d = LOCK;
                end
                LOCK: begin
                    if (cnt_in == exp_q) begin
                        exp_d    = cnt_in + ONE;
                        wrap_inc = (cnt_in == {WIDTH{1'b1}});
                    end else begin
                        mismatch_d   = 1'b1;
                        err_inc      = 1'b1;
                        err_sticky_d = 1'b1;
                        state_d      = FAULT;
                    end
                end
                FAULT: begin
`ifdef COUNTER_MON_RESYNC_EN
                    exp_d   = cnt_in + ONE;
                    state_d = LOCK;
`else
                    state_d = FAULT;
`endif
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = (state_d == LOCK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= HUNT;
            exp_q        <= '0;
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            mismatch_q   <= mismatch_d;
            err_sticky_q <= err_sticky_d;
            locked_q     <= locked_d;
        end
    end

    mon_sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (clr_err),
        .count (err_count)
    );

    mon_sat_counter #(.W(ERR_CNT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_inc),
        .clr   (1'b0),
        .count (wrap_count)
    );

    assign locked     = locked_q;
    assign mismatch   = mismatch_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_counter_seq_monitor.sv
// Directed plus randomized bench for counter_seq_monitor against a behavioural model.
module tb_counter_seq_monitor;

    logic       clk;
    logic       reset;
    logic [3:0] cnt_in;
    logic       cnt_valid;
    logic       sync_clr;
    logic       clr_err;
    logic       locked;
    logic       mismatch;
    logic       err_sticky;
    logic [7:0] err_count;
    logic [7:0] wrap_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: "predicting" means a next value is known, "faulted"
    // means checking is suspended after a deviation.
    bit m_predicting, m_faulted, m_mis, m_sticky;
    int m_exp, m_err, m_wrap;

    counter_seq_monitor #(.WIDTH(4), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_in     (cnt_in),
        .cnt_valid  (cnt_valid),
        .sync_clr   (sync_clr),
        .clr_err    (clr_err),
        .locked     (locked),
        .mismatch   (mismatch),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .wrap_count (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".locked"},     int'(locked),     int'(m_predicting && !m_faulted));
        chk({tag, ".mismatch"},   int'(mismatch),   int'(m_mis));
        chk({tag, ".err_sticky"}, int'(err_sticky), int'(m_sticky));
        chk({tag, ".err_count"},  int'(err_count),  m_err);
        chk({tag, ".wrap_count"}, int'(wrap_count), m_wrap);
    endtask

    task automatic model_reset();
        m_predicting = 0; m_faulted = 0; m_mis = 0; m_sticky = 0;
        m_exp = 0; m_err = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit v, input bit sc, input int d, input bit ce);
        m_mis = 0;
        if (ce) begin
            m_err = 0;
            m_sticky = 0;
        end
        if (sc) begin
            m_predicting = 1; m_faulted = 0; m_exp = 0;
        end else if (v) begin
            if (m_faulted) begin
`ifdef COUNTER_MON_RESYNC_EN
                m_faulted = 0; m_predicting = 1; m_exp = (d + 1) % 16;
`endif
            end else if (!m_predicting) begin
                m_predicting = 1; m_exp = (d + 1) % 16;
            end else if (d == m_exp) begin
                m_exp = (d + 1) % 16;
                if (d == 15 && m_wrap < 255) m_wrap++;
            end else begin
                m_mis = 1; m_sticky = 1; m_faulted = 1; m_predicting = 0;
                if (m_err < 255) m_err++;
            end
        end
    endtask

    // Called at posedge+1: drive, clock, then check one time unit after the edge.
    task automatic step(input bit v, input bit sc, input int d, input bit ce, input string tag);
        cnt_valid = v;
        sync_clr  = sc;
        cnt_in    = 4'(d);
        clr_err   = ce;
        model_step(v, sc, d, ce);
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic mid_cycle_reset(input string tag);
        cnt_valid = 0; sync_clr = 0; clr_err = 0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk_all(tag);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; cnt_in = '0; cnt_valid = 0; sync_clr = 0; clr_err = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        reset = 1'b1;

        // 1: clean run 0..15,0..3 including one wrap
        for (int i = 0; i < 20; i++) step(1, 0, i % 16, 0, "run");
        chk("run.wrap_is_1", int'(wrap_count), 1);

        // gaps are not errors
        step(0, 0, 9, 0, "gap");
        // 2: locked at 5, then 7
        step(1, 0, 4, 0, "t2.s4");
        step(1, 0, 5, 0, "t2.s5");
        step(1, 0, 7, 0, "t2.s7");
        chk("t2.err_is_1", int'(err_count), 1);
        step(0, 0, 0, 0, "t2.pulse_end");
        step(1, 0, 3, 0, "t2.fault_nocheck");

        // 3: sync_clr with cnt_in=9 is unchecked; 0 then passes, 10 fails
        step(1, 1, 0, 0, "t3.clr0");
        for (int i = 0; i <= 9; i++) step(1, 0, i, 0, "t3.ramp");
        step(1, 1, 9, 0, "t3.sclr");
        step(1, 0, 0, 0, "t3.zero_ok");
        step(1, 1, 9, 0, "t3.sclr2");
        step(1, 0, 10, 0, "t3.ten_bad");

        // 4: clr_err coincident with a mismatch, then alone
        step(0, 1, 0, 0, "t4.sclr");
        step(1, 0, 0, 0, "t4.s0");
        step(1, 0, 7, 1, "t4.clr_and_mis");
        chk("t4.err_is_1", int'(err_count), 1);
        step(0, 0, 0, 1, "t4.clr_only");
        chk("t4.err_is_0", int'(err_count), 0);

        // 5: asynchronous reset between edges while locked
        step(0, 1, 0, 0, "t5.sclr");
        step(1, 0, 0, 0, "t5.s0");
        mid_cycle_reset("t5.async");
        step(1, 0, 12, 0, "t5.seed12");
        step(1, 0, 13, 0, "t5.pass13");

        // 6: fault then 3,4,5
        step(1, 0, 2, 0, "t6.bad");
        step(1, 0, 3, 0, "t6.s3");
        step(1, 0, 4, 0, "t6.s4");
        step(1, 0, 5, 0, "t6.s5");
        chk("t6.err_is_1", int'(err_count), 1);

        // 7: drive err_count into saturation
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 0, 0, "t7.sclr");
            step(1, 0, 5, 0, "t7.bad");
        end
        chk("t7.err_sat", int'(err_count), 255);

        // randomized traffic, mostly in-sequence with occasional faults/clears
        for (int i = 0; i < 400; i++) begin
            bit v, sc, ce;
            int d;
            v  = ($urandom_range(0, 9) != 0);
            sc = ($urandom_range(0, 19) == 0);
            ce = ($urandom_range(0, 24) == 0);
            d  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 15)) : m_exp;
            step(v, sc, d, ce, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
